// File: rtl/sdcmd_resp.sv
// sdcmd_resp: card-side SD command-line responder.
// Receives 48-bit host command frames on sdcmd (sampled on sdclk rise),
// hands accepted commands to user logic and serializes the 48-bit response
// (driven on sdclk fall) after NCR sdclk rises.
// Optional feature macro: SDCMD_RESP_CRC_CHECK_EN enables the CRC7 check of
// received commands; without it the received CRC field is ignored.
`timescale 1ns/1ps
module sdcmd_resp #(
  parameter int unsigned NCR = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        sdclk,
  inout  wire         sdcmd,
  output logic        busy,
  output logic        req_valid,
  output logic [5:0]  req_cmd,
  output logic [31:0] req_arg,
  output logic        crc_err,
  output logic        frame_err,
  input  logic        rsp_start,
  input  logic        rsp_skip,
  input  logic [5:0]  rsp_cmd,
  input  logic [31:0] rsp_arg
);

  localparam int unsigned FRAME_W = 48;
  localparam int unsigned RX_W    = 46;  // bits held before the end bit arrives
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned CRC_W   = 7;
  localparam logic [CNT_W-1:0] RX_LAST   = CNT_W'(46);
  localparam logic [CNT_W-1:0] CRC_BITS  = CNT_W'(39);
  localparam logic [CNT_W-1:0] TX_LAST   = CNT_W'(47);
  localparam logic [CNT_W-1:0] NCR_C     = CNT_W'(NCR);
`ifdef SDCMD_RESP_CRC_CHECK_EN
  localparam bit CRC_CHECK_EN = 1'b1;
`else
  localparam bit CRC_CHECK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WAIT,
    S_GAP,
    S_SEND
  } state_t;

  // One CRC7 (x^7 + x^3 + 1) shift step.
  function automatic logic [CRC_W-1:0] crc7_step(input logic [CRC_W-1:0] c, input logic b);
    logic fb;
    fb = b ^ c[CRC_W-1];
    return {c[CRC_W-2:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // CRC7 over a full 40-bit command/response header.
  function automatic logic [CRC_W-1:0] crc7_40(input logic [39:0] d);
    logic [CRC_W-1:0] c;
    c = '0;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
    return c;
  endfunction

  logic sdclk_s1, sdclk_s2, sdclk_s3;
  logic cmd_s1, cmd_s2;

  // Two-stage synchronizers plus an edge-detect stage for sdclk.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sdclk_s1 <= 1'b1;
      sdclk_s2 <= 1'b1;
      sdclk_s3 <= 1'b1;
      cmd_s1   <= 1'b1;
      cmd_s2   <= 1'b1;
    end else begin
      sdclk_s1 <= sdclk;
      sdclk_s2 <= sdclk_s1;
      sdclk_s3 <= sdclk_s2;
      cmd_s1   <= sdcmd;
      cmd_s2   <= cmd_s1;
    end
  end

  logic sd_rise_c, sd_fall_c;
  assign sd_rise_c = sdclk_s2 & ~sdclk_s3;
  assign sd_fall_c = ~sdclk_s2 & sdclk_s3;

  state_t              state_q, state_n;
  logic [RX_W-1:0]     rx_sh_q, rx_sh_n;
  logic [CNT_W-1:0]    rx_cnt_q, rx_cnt_n;
  logic [CRC_W-1:0]    crc_q, crc_n;
  logic [CNT_W-1:0]    gap_q, gap_n;
  logic [FRAME_W-1:0]  tx_sh_q, tx_sh_n;
  logic [CNT_W-1:0]    tx_cnt_q, tx_cnt_n;
  logic                cmd_oe_q, cmd_oe_n;
  logic                cmd_out_q, cmd_out_n;
  logic                busy_n, req_valid_n, crc_err_n, frame_err_n;
  logic [5:0]          req_cmd_n;
  logic [31:0]         req_arg_n;

  logic [RX_W:0]        rx_full_c;
  logic [FRAME_W-1:0]   rsp_frame_c;
  logic [CNT_W-1:0]     gap_inc_c;
  logic                 frame_ok_c, crc_ok_c;

  assign rx_full_c   = {rx_sh_q, cmd_s2};
  assign frame_ok_c  = rx_full_c[RX_W] & rx_full_c[0];
  assign crc_ok_c    = (crc_q == rx_full_c[7:1]);
  assign rsp_frame_c = {2'b00, rsp_cmd, rsp_arg, crc7_40({2'b00, rsp_cmd, rsp_arg}), 1'b1};
  assign gap_inc_c   = (gap_q == '1) ? gap_q : gap_q + CNT_W'(1);

  // Line driver: released unless the response is being sent.
  assign sdcmd = cmd_oe_q ? cmd_out_q : 1'bz;

  // Next-state and registered-output logic.
  always_comb begin
    state_n     = state_q;
    rx_sh_n     = rx_sh_q;
    rx_cnt_n    = rx_cnt_q;
    crc_n       = crc_q;
    gap_n       = gap_q;
    tx_sh_n     = tx_sh_q;
    tx_cnt_n    = tx_cnt_q;
    cmd_oe_n    = cmd_oe_q;
    cmd_out_n   = cmd_out_q;
    req_valid_n = 1'b0;
    crc_err_n   = 1'b0;
    frame_err_n = 1'b0;
    req_cmd_n   = req_cmd;
    req_arg_n   = req_arg;

    case (state_q)
      S_IDLE: begin
        cmd_oe_n = 1'b0;
        if (sd_rise_c && !cmd_s2) begin
          state_n  = S_RECV;
          rx_cnt_n = '0;
          crc_n    = '0;
        end
      end

      S_RECV: begin
        if (sd_rise_c) begin
          rx_sh_n  = rx_full_c[RX_W-1:0];
          rx_cnt_n = rx_cnt_q + CNT_W'(1);
          if (rx_cnt_q < CRC_BITS) crc_n = crc7_step(crc_q, cmd_s2);
          if (rx_cnt_q == RX_LAST) begin
            gap_n = '0;
            if (!frame_ok_c) begin
              frame_err_n = 1'b1;
              state_n     = S_IDLE;
            end else if (CRC_CHECK_EN && !crc_ok_c) begin
              crc_err_n = 1'b1;
              state_n   = S_IDLE;
            end else begin
              req_valid_n = 1'b1;
              req_cmd_n   = rx_full_c[45:40];
              req_arg_n   = rx_full_c[39:8];
              state_n     = S_WAIT;
            end
          end
        end
      end

      S_WAIT: begin
        cmd_oe_n = 1'b0;
        if (sd_rise_c) gap_n = gap_inc_c;
        if (rsp_skip) begin
          state_n = S_IDLE;
        end else if (rsp_start) begin
          tx_sh_n = rsp_frame_c;
          state_n = S_GAP;
        end else if (sd_rise_c && !cmd_s2) begin
          state_n  = S_RECV;
          rx_cnt_n = '0;
          crc_n    = '0;
        end
      end

      S_GAP: begin
        if (sd_rise_c) gap_n = gap_inc_c;
        if (sd_fall_c && (gap_q >= NCR_C)) begin
          cmd_oe_n  = 1'b1;
          cmd_out_n = tx_sh_q[FRAME_W-1];
          tx_sh_n   = {tx_sh_q[FRAME_W-2:0], 1'b0};
          tx_cnt_n  = '0;
          state_n   = S_SEND;
        end
      end

      S_SEND: begin
        if (sd_fall_c) begin
          if (tx_cnt_q == TX_LAST) begin
            cmd_oe_n  = 1'b0;
            cmd_out_n = 1'b1;
            state_n   = S_IDLE;
          end else begin
            cmd_out_n = tx_sh_q[FRAME_W-1];
            tx_sh_n   = {tx_sh_q[FRAME_W-2:0], 1'b0};
            tx_cnt_n  = tx_cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_n  = S_IDLE;
        cmd_oe_n = 1'b0;
      end
    endcase

    busy_n = (state_n != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      rx_sh_q   <= '0;
      rx_cnt_q  <= '0;
      crc_q     <= '0;
      gap_q     <= '0;
      tx_sh_q   <= '0;
      tx_cnt_q  <= '0;
      cmd_oe_q  <= 1'b0;
      cmd_out_q <= 1'b1;
      busy      <= 1'b0;
      req_valid <= 1'b0;
      crc_err   <= 1'b0;
      frame_err <= 1'b0;
      req_cmd   <= '0;
      req_arg   <= '0;
    end else begin
      state_q   <= state_n;
      rx_sh_q   <= rx_sh_n;
      rx_cnt_q  <= rx_cnt_n;
      crc_q     <= crc_n;
      gap_q     <= gap_n;
      tx_sh_q   <= tx_sh_n;
      tx_cnt_q  <= tx_cnt_n;
      cmd_oe_q  <= cmd_oe_n;
      cmd_out_q <= cmd_out_n;
      busy      <= busy_n;
      req_valid <= req_valid_n;
      crc_err   <= crc_err_n;
      frame_err <= frame_err_n;
      req_cmd   <= req_cmd_n;
      req_arg   <= req_arg_n;
    end
  end

endmodule

// File: tb/tb_sdcmd_resp.sv
// Testbench for sdcmd_resp: host-side frame driver, user responder and a
// reference model (frame rules + polynomial-division CRC7).
`timescale 1ns/1ps
module tb_sdcmd_resp;

  localparam int unsigned NCR = 2;
`ifdef SDCMD_RESP_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic sdclk = 1'b0;
  logic rstn = 1'b0;
  logic host_oe = 1'b0;
  logic host_bit = 1'b1;
  wire  sdcmd;

  logic        busy, req_valid, crc_err, frame_err;
  logic [5:0]  req_cmd;
  logic [31:0] req_arg;
  logic        rsp_start = 1'b0;
  logic        rsp_skip = 1'b0;
  logic [5:0]  rsp_cmd = '0;
  logic [31:0] rsp_arg = '0;

  pullup (sdcmd);
  assign sdcmd = host_oe ? host_bit : 1'bz;

  sdcmd_resp #(.NCR(NCR)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .sdclk     (sdclk),
    .sdcmd     (sdcmd),
    .busy      (busy),
    .req_valid (req_valid),
    .req_cmd   (req_cmd),
    .req_arg   (req_arg),
    .crc_err   (crc_err),
    .frame_err (frame_err),
    .rsp_start (rsp_start),
    .rsp_skip  (rsp_skip),
    .rsp_cmd   (rsp_cmd),
    .rsp_arg   (rsp_arg)
  );

  always #5  clk   = ~clk;
  always #50 sdclk = ~sdclk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_rv = 0;
  int n_ce = 0;
  int n_fe = 0;
  int user_mode = 0;  // 0 none, 1 start, 2 skip, 3 start+skip
  int user_dly = 0;
  logic [5:0]  exp_cmd = '0;
  logic [31:0] exp_arg = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // CRC7 as the remainder of d * x^7 divided by x^7 + x^3 + 1.
  function automatic logic [6:0] m_crc7(input logic [39:0] d);
    logic [46:0] r;
    r = {d, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  // Pulse counters.
  always @(negedge clk) begin
    if (req_valid) n_rv++;
    if (crc_err)   n_ce++;
    if (frame_err) n_fe++;
  end

  // User side: reacts to req_valid according to user_mode/user_dly.
  initial begin
    forever begin
      @(negedge clk);
      if (req_valid && user_mode != 0) begin
        repeat (user_dly) @(negedge clk);
        rsp_start = (user_mode == 1) || (user_mode == 3);
        rsp_skip  = (user_mode == 2) || (user_mode == 3);
        @(negedge clk);
        rsp_start = 1'b0;
        rsp_skip  = 1'b0;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic host_send(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      @(negedge sdclk);
      host_oe  = 1'b1;
      host_bit = f[i];
    end
    @(negedge sdclk);
    host_oe  = 1'b0;
    host_bit = 1'b1;
  endtask

  // Waits (bounded) for a response start bit, then reads the whole frame.
  task automatic capture(output int pos, output logic [47:0] got);
    pos = 0;
    got = '1;
    for (int k = 1; k <= int'(NCR) + 10; k++) begin
      @(posedge sdclk);
      if (sdcmd === 1'b0) begin
        pos = k;
        break;
      end
    end
    if (pos != 0) begin
      got[47] = 1'b0;
      for (int b = 46; b >= 0; b--) begin
        @(posedge sdclk);
        got[b] = sdcmd;
      end
    end
  endtask

  // One host command plus user reaction, checked against the model.
  task automatic xact(input logic tx, input logic [5:0] c, input logic [31:0] a,
                      input logic [6:0] crc, input logic eb,
                      input int mode, input int dly, input int exp_pos);
    logic [47:0] f, got, exp_f;
    logic crc_ok, e_fe, e_ce, e_rv;
    int pos, lows;
    f      = {1'b0, tx, c, a, crc, eb};
    crc_ok = (crc == m_crc7({1'b0, tx, c, a}));
    e_fe   = !(tx && eb);
    e_ce   = !e_fe && CRC_EN && !crc_ok;
    e_rv   = !e_fe && !e_ce;
    if (e_rv) begin
      exp_cmd = c;
      exp_arg = a;
    end
    user_mode = mode;
    user_dly  = dly;
    n_rv = 0;
    n_ce = 0;
    n_fe = 0;
    host_send(f);
    if (e_rv && mode == 1) begin
      exp_f = {2'b00, rsp_cmd, rsp_arg, m_crc7({2'b00, rsp_cmd, rsp_arg}), 1'b1};
      capture(pos, got);
      check_eq("rsp_start_pos", 64'(pos), 64'(exp_pos));
      check_eq("rsp_frame", 64'(got), 64'(exp_f));
      repeat (2) @(posedge sdclk);
      check_eq("line_released", 64'(sdcmd), 64'(1));
    end else begin
      lows = 0;
      repeat (NCR + 6) begin
        @(posedge sdclk);
        if (sdcmd !== 1'b1) lows++;
      end
      check_eq("line_idle_lows", 64'(lows), 64'(0));
    end
    @(negedge clk);
    check_eq("req_valid_pulses", 64'(n_rv), 64'(e_rv));
    check_eq("crc_err_pulses", 64'(n_ce), 64'(e_ce));
    check_eq("frame_err_pulses", 64'(n_fe), 64'(e_fe));
    check_eq("req_cmd", 64'(req_cmd), 64'(exp_cmd));
    check_eq("req_arg", 64'(req_arg), 64'(exp_arg));
    check_eq("busy_after", 64'(busy), 64'(e_rv && mode == 0));
    user_mode = 0;
  endtask

  initial begin
    logic [5:0]  c;
    logic [31:0] a;
    logic [6:0]  cr;
    logic        tx, eb;
    int          k, mode, dly, pos;

    rstn = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_req_valid", 64'(req_valid), 64'(0));
    check_eq("rst_crc_err", 64'(crc_err), 64'(0));
    check_eq("rst_frame_err", 64'(frame_err), 64'(0));
    check_eq("rst_req_cmd", 64'(req_cmd), 64'(0));
    check_eq("rst_req_arg", 64'(req_arg), 64'(0));
    check_eq("rst_line", 64'(sdcmd), 64'(1));
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge sdclk);

    // CMD0, declined by the user.
    xact(1'b1, 6'd0, 32'h0, 7'h4A, 1'b1, 2, 0, 0);

    // CMD8, answered promptly.
    rsp_cmd = 6'd8;
    rsp_arg = 32'h0000_01AA;
    xact(1'b1, 6'd8, 32'h0000_01AA, 7'h43, 1'b1, 1, 0, int'(NCR) + 1);

    // CMD8 with a corrupted CRC.
    xact(1'b1, 6'd8, 32'h0000_01AA, 7'h42, 1'b1, 2, 0, 0);

    // End bit low with CRC also wrong: framing error only.
    xact(1'b1, 6'd8, 32'h0000_01AA, 7'h42, 1'b0, 2, 0, 0);

    // Command left pending, then CMD55 replaces it; start and skip together.
    a = $urandom;
    xact(1'b1, 6'd17, a, m_crc7({2'b01, 6'd17, a}), 1'b1, 0, 0, 0);
    xact(1'b1, 6'd55, 32'h1234_0000, m_crc7({2'b01, 6'd55, 32'h1234_0000}), 1'b1, 3, 0, 0);

    // Late answer: accepted after the 4th rise, start bit seen on the 5th rise.
    rsp_cmd = 6'($urandom);
    rsp_arg = $urandom;
    a = $urandom;
    xact(1'b1, 6'd13, a, m_crc7({2'b01, 6'd13, a}), 1'b1, 1, 42, 5);

    // Reset in the middle of a response.
    rsp_cmd   = 6'd3;
    rsp_arg   = 32'h0;
    user_mode = 1;
    user_dly  = 0;
    host_send({1'b0, 1'b1, 6'd0, 32'h0, 7'h4A, 1'b1});
    pos = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge sdclk);
      if (sdcmd === 1'b0) begin
        pos = i;
        break;
      end
    end
    check_eq("rst_send_start_pos", 64'(pos), 64'(int'(NCR) + 1));
    repeat (20) @(posedge sdclk);
    check_eq("rst_send_bit20", 64'(sdcmd), 64'(0));
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_send_line", 64'(sdcmd), 64'(1));
    check_eq("rst_send_busy", 64'(busy), 64'(0));
    exp_cmd   = '0;
    exp_arg   = '0;
    user_mode = 0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge sdclk);
    xact(1'b1, 6'd0, 32'h0, 7'h4A, 1'b1, 2, 0, 0);

    // Randomized commands: good, bad CRC, or bad framing.
    for (int it = 0; it < 12; it++) begin
      c  = 6'($urandom);
      a  = $urandom;
      k  = $urandom_range(0, 3);
      tx = 1'b1;
      eb = 1'b1;
      cr = m_crc7({2'b01, c, a});
      if (k == 2) cr = cr ^ 7'(1 + $urandom_range(0, 126));
      if (k == 3) begin
        if ($urandom_range(0, 1) == 1) eb = 1'b0;
        else tx = 1'b0;
      end
      rsp_cmd = 6'($urandom);
      rsp_arg = $urandom;
      mode    = $urandom_range(1, 2);
      dly     = $urandom_range(0, 3);
      xact(tx, c, a, cr, eb, mode, dly, int'(NCR) + 1);
      repeat ($urandom_range(1, 3)) @(negedge sdclk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sdcmd_resp.md
# sdcmd_resp

Card-side responder for the SD command line. It samples host-driven `sdclk`/`sdcmd` and deserializes 48-bit command frames, checking the framing bits and CRC7. Each accepted command is presented to user logic, which answers by supplying the response fields. The block then serializes a 48-bit response (R1/R6/R7 format) back onto `sdcmd`. It sits in the SD card emulation / loopback model and forms the far end of the host command controller.

## Interface
- `NCR`, default 2: number of `sdclk` rising edges between the command end bit and the response start bit; legal range 1..63.
- `clk`  in  1  system clock; all logic runs on its rising edge.
- `rstn`  in  1  synchronous, active-low reset.
- `sdclk`  in  1  SD clock from the host; asynchronous to `clk`, with period at least 8 `clk` cycles.
- `sdcmd`  inout  1  SD command line, tri-stated when not driven.
- `busy`  out  1  high from start-bit detection until the response is released or skipped.
- `req_valid`  out  1  one-`clk` pulse: a valid command has been received.
- `req_cmd`  out  6  command index, held until the next `req_valid`.
- `req_arg`  out  32  command argument, held until the next `req_valid`.
- `crc_err`  out  1  one-`clk` pulse: received CRC7 mismatched.
- `frame_err`  out  1  one-`clk` pulse: transmission bit ≠ 1 or end bit ≠ 1.
- `rsp_start`  in  1  user request to send a response; honored only in WAIT.
- `rsp_skip`  in  1  user declines to respond; honored only in WAIT; wins over `rsp_start`.
- `rsp_cmd`  in  6  response index field, captured on an accepted `rsp_start`.
- `rsp_arg`  in  32  response argument field, captured on an accepted `rsp_start`.

## Operation
- **Synchronization:** `sdclk` and `sdcmd` input each pass a 2-FF synchronizer. Rise and fall strobes are edge-detected from the synchronized `sdclk`. Bits are sampled on rise strobes; driven values change on fall strobes.
- **IDLE:** `sdcmd` released. Synchronized `sdcmd` = 0 on a rise strobe is a start bit → RECV, `busy` = 1.
- **RECV:** shift 47 more bits on rise strobes. Received layout: transmission bit, cmd[5:0], arg[31:0], crc[6:0], end bit.
  - CRC7 (x^7+x^3+1, init 0) covers the start bit through arg (40 bits).
  - After the end bit:
    - Framing bad → `frame_err` pulse, → IDLE.
    - Otherwise, CRC bad → `crc_err` pulse, → IDLE.
    - Otherwise → `req_valid` pulse, update `req_cmd`/`req_arg`, → WAIT.
  - When `frame_err` and `crc_err` conditions coincide, only `frame_err` pulses.
- **WAIT:** `sdcmd` released.
  - `rsp_skip` → IDLE.
  - `rsp_start` → capture the response fields, → GAP.
  - A new start bit on the line → drop the pending command, → RECV, with no pulses.
- **GAP:** count rise strobes from the command end bit; counting started at end-bit sampling, not at `rsp_start`. At count ≥ `NCR`, the next fall strobe drives the start bit → SEND. If the user answers late, drive on the first fall strobe after acceptance.
- **SEND:** on successive fall strobes drive 0, 0, `rsp_cmd`, `rsp_arg` (MSB first), CRC7 of those 40 bits, then 1.
  - On the fall strobe after the end bit, release `sdcmd` → IDLE, `busy` = 0.
  - `rsp_start`/`rsp_skip` are ignored outside WAIT.
- **Reset:** synchronous reset at any state → IDLE on the next `clk`, with `sdcmd` released.
- **Reset values:** `busy` 0, `req_valid` 0, `crc_err` 0, `frame_err` 0, `req_cmd` 0, `req_arg` 0, `sdcmd` Z. Synchronizers reset to 1.

## Timing
- `req_valid`, `crc_err`, `frame_err` assert 1 `clk` after the `clk` cycle that processes the end-bit rise strobe; the rise strobe itself lags the pin by 3 `clk`.
- The `sdcmd` output changes 1 `clk` after the processed fall strobe, which lags the pin by 3 `clk`. The total 4 `clk` margin fits within the half `sdclk` period at the ≥8× ratio.
- Response start bit: first fall strobe after the `NCR`-th rise following the end bit (`NCR` = 2 → falls 2.5 `sdclk` after the command end bit).
- Line driven for exactly 48 `sdclk` periods, then Z.

## Configuration
- `SDCMD_RESP_CRC_CHECK_EN` defined: CRC7 is checked as above.
- Not defined: the CRC field is shifted in but ignored. `crc_err` is tied 0 and every well-framed command yields `req_valid`. Response CRC generation is unaffected.

## Test plan
- CMD0, arg 0x00000000, CRC 0x4A → `req_valid`, `req_cmd` = 0, `req_arg` = 0. Then `rsp_skip` → line stays Z, `busy` falls.
- CMD8, arg 0x000001AA, CRC 0x43; respond `rsp_cmd` = 8, `rsp_arg` = 0x000001AA → 48-bit response starts 2.5 `sdclk` after the end bit, CRC matches the software CRC7 model, end bit 1, then Z.
- CMD8 with CRC 0x42 → `crc_err` pulse, no `req_valid`, block returns to IDLE. With the macro undefined → `req_valid` instead.
- Command with the end bit forced to 0 → `frame_err` pulse only.
- In WAIT, host issues a new CMD55, arg 0x12340000 → single `req_valid` with `req_cmd` = 55. `rsp_start` and `rsp_skip` high in the same cycle → no response.
- Assert `rstn` = 0 mid-SEND (bit 20) → `sdcmd` Z and `busy` 0 within 1 `clk`. The next CMD0 is received normally.
